// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, fetch state encoding and HALT opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int PC_WIDTH    = 10;
    localparam int INSTR_WIDTH = 9;

    localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = 9'b111_000_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid
//  Description : One-entry skid buffer holding an instruction word and its PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_load,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]    i_pc,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_pc
);

    logic                   r_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_pc;

    // Flush outranks a load so a redirect never leaves a stale entry behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch with stall skid buffer, redirects and halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    start_addr,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic                   imem_rd_en,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   jump_en,
    input  logic [PC_WIDTH-1:0]    jump_target,
    input  logic                   halt,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   halted,
    output logic [15:0]            cycle_count
);

    fetch_state_t           r_state;
    fetch_state_t           w_state_next;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    r_resp_pc;
    logic                   r_resp_valid;
    logic [15:0]            r_cycle_count;

    logic                   w_skid_valid;
    logic [INSTR_WIDTH-1:0] w_skid_instr;
    logic [PC_WIDTH-1:0]    w_skid_pc;

    logic                   w_accept;
    logic                   w_redirect;
    logic                   w_start_go;
    logic                   w_fetch;

    assign w_accept   = instr_valid && !stall;
    assign w_redirect = w_accept && (halt || jump_en || branch_taken);
    assign w_start_go = start && (r_state != ST_RUN);
    assign w_fetch    = (r_state == ST_RUN) && !(instr_valid && stall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start)               w_state_next = ST_RUN;
            ST_RUN:    if (w_accept && halt)    w_state_next = ST_HALTED;
            ST_HALTED: if (start)               w_state_next = ST_RUN;
            default:                            w_state_next = ST_IDLE;
        endcase
    end

    // A response is only worth keeping if no redirect or halt was accepted
    // in the cycle that requested it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_pc     <= '0;
            r_cycle_count <= '0;
        end else begin
            r_resp_valid <= w_fetch && !w_redirect;
            if (w_fetch) begin
                r_resp_pc <= r_pc;
            end
            if (w_start_go) begin
                r_pc          <= start_addr;
                r_cycle_count <= '0;
            end else if (r_state == ST_RUN) begin
                if (r_cycle_count != 16'hFFFF) begin
                    r_cycle_count <= r_cycle_count + 16'd1;
                end
                if (w_accept && !halt && jump_en) begin
                    r_pc <= jump_target;
                end else if (w_accept && !halt && branch_taken) begin
                    r_pc <= branch_target;
                end else if (w_fetch) begin
                    r_pc <= r_pc + PC_WIDTH'(1);
                end
            end
        end
    end

    // Fetches stop while a stalled word is presented, so the skid entry and
    // a fresh response can never coexist.
    fetch_skid u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_flush (w_start_go || w_redirect),
        .i_load  (r_resp_valid && stall && !w_skid_valid),
        .i_instr (imem_rdata),
        .i_pc    (r_resp_pc),
        .i_pop   (w_skid_valid && !stall),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    assign instr_valid = w_skid_valid || r_resp_valid;
    assign instruction = w_skid_valid ? w_skid_instr :
                         (r_resp_valid ? imem_rdata : '0);
    assign pc_out      = w_skid_valid ? w_skid_pc :
                         (r_resp_valid ? r_resp_pc : '0);
    assign imem_rd_en  = w_fetch;
    assign imem_addr   = r_pc;
    assign halted      = (r_state == ST_HALTED);
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Vector table, directed corner sequences and random stimulus
//                against a queue-based fetch model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] start_addr;
    logic [9:0] imem_addr;
    logic       imem_rd_en;
    logic [8:0] imem_rdata = '0;
    logic       stall;
    logic       branch_taken;
    logic [9:0] branch_target;
    logic       jump_en;
    logic [9:0] jump_target;
    logic       halt;
    logic [8:0] instruction;
    logic       instr_valid;
    logic [9:0] pc_out;
    logic       halted;
    logic [15:0] cycle_count;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_addr    (start_addr),
        .imem_addr     (imem_addr),
        .imem_rd_en    (imem_rd_en),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .halt          (halt),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .halted        (halted),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [1024];

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    typedef struct {
        bit       st;
        bit [9:0] sa;
        bit       stl;
        bit       br;
        bit [9:0] bt;
        bit       jp;
        bit [9:0] jt;
        bit       hl;
        bit       ev;
        bit [9:0] epc;
        bit       eh;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 run, 2 halted; q holds fetched
    // addresses not yet consumed by the decoder.
    int m_mode, m_pc, m_count;
    int q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit st, int sa, bit stl, bit br, int bt, bit jp, int jt,
                                bit hl, bit ev, int epc, bit eh);
        vec_t v;
        v.st = st;  v.sa = sa[9:0]; v.stl = stl;
        v.br = br;  v.bt = bt[9:0]; v.jp = jp; v.jt = jt[9:0];
        v.hl = hl;  v.ev = ev; v.epc = epc[9:0]; v.eh = eh;
        return v;
    endfunction

    function automatic vec_t vr(int epc);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, epc, 0);
    endfunction

    function automatic vec_t vn(bit eh);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eh);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_count = 0;
        q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instruction, 0);
        chk({tag, "_pc_out"}, pc_out, 0);
        chk({tag, "_rd_en"}, imem_rd_en, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_count"}, cycle_count, 0);
    endtask

    // One clock: drive inputs, compare against the model (and optionally
    // the vector's constant expectations), then advance the model.
    task automatic step(input vec_t v, input bit use_tbl, input int idx);
        bit e_valid, e_rd, acc;
        int e_pc;
        @(negedge clk);
        start = v.st; start_addr = v.sa; stall = v.stl;
        branch_taken = v.br; branch_target = v.bt;
        jump_en = v.jp; jump_target = v.jt; halt = v.hl;
        #1;
        e_valid = (m_mode == 1) && (q.size() > 0);
        e_pc    = e_valid ? q[0] : 0;
        e_rd    = (m_mode == 1) && !(e_valid && stall);
        chk("model_valid", instr_valid, e_valid);
        chk("model_pc_out", pc_out, e_pc);
        chk("model_instr", instruction, e_valid ? mem[e_pc] : 9'd0);
        chk("model_rd_en", imem_rd_en, e_rd);
        if (e_rd) chk("model_addr", imem_addr, m_pc);
        chk("model_halted", halted, m_mode == 2);
        chk("model_count", cycle_count, m_count);
        if (use_tbl) begin
            chk($sformatf("tbl%0d_valid", idx), instr_valid, v.ev);
            if (v.ev) chk($sformatf("tbl%0d_pc_out", idx), pc_out, v.epc);
            chk($sformatf("tbl%0d_halted", idx), halted, v.eh);
        end
        if (m_mode == 1) begin
            acc = e_valid && !stall;
            m_count = (m_count < 65535) ? m_count + 1 : 65535;
            if (acc) void'(q.pop_front());
            if (e_rd) begin
                q.push_back(m_pc);
                m_pc = (m_pc + 1) % 1024;
            end
            if (acc && halt) begin
                m_mode = 2; q.delete();
            end else if (acc && jump_en) begin
                m_pc = jump_target; q.delete();
            end else if (acc && branch_taken) begin
                m_pc = branch_target; q.delete();
            end
        end else if (start) begin
            m_mode = 1; m_pc = start_addr; m_count = 0;
            q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v0;
        v0 = vn(0);

        for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom);

        reset = 1'b1; start = 0; start_addr = 0; stall = 0;
        branch_taken = 0; branch_target = 0; jump_en = 0; jump_target = 0; halt = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        model_reset();

        // Straight line, stall, redirects, wrap, halt and restart.
        tbl.push_back(mk(1, 'h010, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vn(0));
        for (int a = 'h010; a <= 'h013; a++) tbl.push_back(vr(a));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 'h014, 0));
        tbl.push_back(vr('h014));
        for (int a = 'h015; a <= 'h01F; a++) tbl.push_back(vr(a));
        tbl.push_back(mk(0, 0, 0, 1, 'h100, 0, 0, 0, 1, 'h020, 0));
        tbl.push_back(vn(0));
        tbl.push_back(vr('h100));
        tbl.push_back(mk(0, 0, 0, 1, 'h180, 1, 'h200, 0, 1, 'h101, 0));
        tbl.push_back(mk(0, 0, 0, 1, 'h300, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vr('h200));
        tbl.push_back(mk(0, 0, 1, 1, 'h300, 0, 0, 0, 1, 'h201, 0));
        tbl.push_back(vr('h201));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h3FE, 0, 1, 'h202, 0));
        tbl.push_back(vn(0));
        tbl.push_back(vr('h3FE));
        tbl.push_back(vr('h3FF));
        tbl.push_back(vr('h000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h001, 0));
        tbl.push_back(vn(1));
        tbl.push_back(mk(1, 'h050, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(vn(0));
        tbl.push_back(vr('h050));
        tbl.push_back(vr('h051));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1, i);

        // Reset during a stall with the skid entry occupied.
        step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        chk("skid_full_valid", instr_valid, 1);
        chk("skid_full_pc", pc_out, 'h052);
        #1 reset = 1'b1;
        #1;
        chk_zero("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b0; stall = 0;
        for (int k = 0; k < 4; k++) begin
            step(v0, 0, 0);
            chk("post_rst_no_valid", instr_valid, 0);
        end

        // Halt accepted at cycle_count 37, then restart.
        step(mk(1, 'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        for (int k = 0; k < 100 && m_count != 37; k++) step(v0, 0, 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0);
        chk("halt_at_count", cycle_count, 37);
        chk("halt_at_valid", instr_valid, 1);
        step(v0, 0, 0);
        chk("halt_halted", halted, 1);
        chk("halt_rd_en", imem_rd_en, 0);
        chk("halt_valid", instr_valid, 0);
        chk("halt_count", cycle_count, 38);
        step(v0, 0, 0);
        step(v0, 0, 0);
        chk("halt_count_frozen", cycle_count, 38);
        step(mk(1, 'h050, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        step(v0, 0, 0);
        chk("restart_count", cycle_count, 0);
        chk("restart_halted", halted, 0);
        step(v0, 0, 0);
        chk("restart_valid", instr_valid, 1);
        chk("restart_pc", pc_out, 'h050);

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            vec_t r;
            r = mk($urandom_range(0, 29) == 0, $urandom_range(0, 1023),
                   $urandom_range(0, 9) < 3,
                   $urandom_range(0, 19) == 0, $urandom_range(0, 1023),
                   $urandom_range(0, 29) == 0, $urandom_range(0, 1023),
                   $urandom_range(0, 99) == 0, 0, 0, 0);
            step(r, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
